// File: rtl/irq_ctrl_v2_if.sv
// CPU-side bus and interrupt handshake bundle for irq_ctrl_v2.
interface irq_ctrl_v2_if #(
  parameter int unsigned PRIO_BITS = 2
);
  logic                 bus_write;
  logic                 bus_read;
  logic [23:0]          bus_address;
  logic [7:0]           bus_data_in;
  logic [7:0]           bus_data_out;
  logic [PRIO_BITS-1:0] cpu_irq;
  logic                 cpu_nmi;
  logic [7:0]           cpu_vector;
  logic                 cpu_iack;

  modport master (
    output bus_write, bus_read, bus_address, bus_data_in, cpu_iack,
    input  bus_data_out, cpu_irq, cpu_nmi, cpu_vector
  );

  modport slave (
    input  bus_write, bus_read, bus_address, bus_data_in, cpu_iack,
    output bus_data_out, cpu_irq, cpu_nmi, cpu_vector
  );
endinterface

// File: rtl/irq_ctrl_v2.sv
// Interrupt controller: edge-latched sources, per-group priority, NMI sources,
// and a registered request/acknowledge handshake with the CPU.
module irq_ctrl_v2 #(
  parameter int unsigned          NUM_SRC   = 32,
  parameter int unsigned          NUM_GRP   = 9,
  parameter int unsigned          PRIO_BITS = 2,
  parameter logic [NUM_SRC*4-1:0] GRP_MAP   = (NUM_SRC*4)'(128'h4445_5555_5556_6888_8777_7001_1223_3000),
  parameter logic [NUM_SRC-1:0]   NMI_MASK  = NUM_SRC'(32'h7),
  parameter logic [23:0]          BASE_ADDR = 24'h2020
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] irqs,
  irq_ctrl_v2_if.slave       bus
);
  localparam int unsigned PW    = NUM_GRP * PRIO_BITS;
  localparam int unsigned PB    = (PW + 7) / 8;
  localparam int unsigned EB    = NUM_SRC / 8;
  localparam int unsigned NREG  = PB + 2 * EB;
  localparam int unsigned SRC_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_ACK} state_t;

  state_t               state_q;
  logic [NUM_SRC-1:0]   irq_q;
  logic [NUM_SRC-1:0]   active_q;
  logic [NUM_SRC-1:0]   enable_q;
  logic [PW-1:0]        prio_q;
  logic [SRC_W-1:0]     src_q;
  logic [PRIO_BITS-1:0] lvl_q;
  logic                 nmi_q;

  logic [23:0]          off;
  logic                 sel;
  logic [PB*8-1:0]      prio_pad;
  logic [PB*8-1:0]      prio_wr;
  logic [NUM_SRC-1:0]   enable_nxt;
  logic [NUM_SRC-1:0]   w1c;
  logic [NUM_SRC-1:0]   ack_clr;
  logic [NUM_SRC-1:0]   active_nxt;
  logic [7:0]           rd_byte;

  logic                 win_found;
  logic                 win_nmi;
  logic [PRIO_BITS-1:0] win_lvl;
  logic [SRC_W-1:0]     win_src;
  logic [PRIO_BITS-1:0] grp_lvl [16];

  // Address below the base wraps to a large offset and is rejected by the same compare.
  assign off      = bus.bus_address - BASE_ADDR;
  assign sel      = off < 24'(NREG);
  assign prio_pad = (PB*8)'(prio_q);

  always_comb begin : read_mux
    rd_byte = 8'h00;
    for (int b = 0; b < PB; b++)
      if (off == 24'(b)) rd_byte = prio_pad[b*8 +: 8];
    for (int b = 0; b < EB; b++) begin
      if (off == 24'(PB + b))      rd_byte = enable_q[b*8 +: 8];
      if (off == 24'(PB + EB + b)) rd_byte = active_q[b*8 +: 8];
    end
  end

  assign bus.bus_data_out = (bus.bus_read && sel) ? rd_byte : 8'h00;

  always_comb begin : write_decode
    prio_wr    = prio_pad;
    enable_nxt = enable_q;
    w1c        = '0;
    if (bus.bus_write) begin
      for (int b = 0; b < PB; b++)
        if (off == 24'(b)) prio_wr[b*8 +: 8] = bus.bus_data_in;
      for (int b = 0; b < EB; b++) begin
        if (off == 24'(PB + b))      enable_nxt[b*8 +: 8] = bus.bus_data_in;
        if (off == 24'(PB + EB + b)) w1c[b*8 +: 8]        = bus.bus_data_in;
      end
    end
  end

  // Hardware edge set is applied last so it wins over any clear in the same cycle.
  always_comb begin : active_update
    ack_clr = '0;
    if (state_q == S_REQ && bus.cpu_iack) ack_clr[src_q] = 1'b1;
    active_nxt = (active_q & ~w1c & ~ack_clr) | (irqs & ~irq_q);
  end

  for (genvar g = 0; g < 16; g++) begin : g_grp
    if (g < NUM_GRP) begin : g_used
      assign grp_lvl[g] = prio_q[g*PRIO_BITS +: PRIO_BITS];
    end else begin : g_unused
      assign grp_lvl[g] = '0;
    end
  end

  always_comb begin : arbiter
    logic [PRIO_BITS-1:0] lvl_i;
    lvl_i     = '0;
    win_found = 1'b0;
    win_nmi   = 1'b0;
    win_lvl   = '0;
    win_src   = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      lvl_i = NMI_MASK[i] ? '1 : grp_lvl[GRP_MAP[i*4 +: 4]];
      if (active_q[i] && enable_q[i] && (NMI_MASK[i] || lvl_i != '0)) begin
        if (!win_found || (NMI_MASK[i] && !win_nmi) ||
            (!NMI_MASK[i] && !win_nmi && lvl_i > win_lvl)) begin
          win_found = 1'b1;
          win_nmi   = NMI_MASK[i];
          win_lvl   = lvl_i;
          win_src   = SRC_W'(i);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      irq_q          <= '0;
      active_q       <= '0;
      enable_q       <= '0;
      prio_q         <= '0;
      src_q          <= '0;
      lvl_q          <= '0;
      nmi_q          <= 1'b0;
      bus.cpu_irq    <= '0;
      bus.cpu_nmi    <= 1'b0;
      bus.cpu_vector <= 8'h00;
    end else begin
      irq_q    <= irqs;
      active_q <= active_nxt;
      enable_q <= enable_nxt;
      prio_q   <= prio_wr[PW-1:0];
      case (state_q)
        S_IDLE: begin
          bus.cpu_irq <= '0;
          bus.cpu_nmi <= 1'b0;
          if (win_found) begin
            state_q <= S_REQ;
            src_q   <= win_src;
            lvl_q   <= win_lvl;
            nmi_q   <= win_nmi;
          end
        end
        S_REQ: begin
          bus.cpu_vector <= 8'({src_q, 1'b0});
          if (bus.cpu_iack) begin
            state_q     <= S_ACK;
            bus.cpu_irq <= '0;
            bus.cpu_nmi <= 1'b0;
          end else if (win_found) begin
            // Present the latched request while re-arbitrating for the next cycle.
            bus.cpu_irq <= nmi_q ? '1 : lvl_q;
            bus.cpu_nmi <= nmi_q;
            src_q       <= win_src;
            lvl_q       <= win_lvl;
            nmi_q       <= win_nmi;
          end else begin
            state_q     <= S_IDLE;
            bus.cpu_irq <= '0;
            bus.cpu_nmi <= 1'b0;
          end
        end
        S_ACK: begin
          bus.cpu_irq <= '0;
          bus.cpu_nmi <= 1'b0;
          if (!bus.cpu_iack) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule
